// File: rtl/deparser.sv
// ---------------------------------------------------------------------------
// deparser
//
// Reads a stored packet back out of packet memory one 32-bit word at a time
// and emits it as a stream of output beats. Each beat takes two cycles:
// a LOAD cycle that presents the read address, and a SEND cycle that holds
// the beat until the sink accepts it.
//
// Optional feature (compile-time macro DP_STRIP_L2_EN):
//   defined   - emission starts at the hdr1 offset, dropping the Ethernet
//               header, unless hdr1 is NO_HEADER (then it starts at 0).
//   undefined - emission always starts at offset 0 (whole packet).
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start_i        level request to emit one packet
//   pkt_len_i      packet length in bytes, sampled at start
//   parsed_hdrs_i  header offsets {hdr0, hdr1}, hdr0 in the upper word
//   mem_ce_o       packet-memory read enable
//   mem_we_o       packet-memory write enable (always 0)
//   mem_addr_o     byte address of the word being read
//   mem_width_o    number of valid bytes in the word being read (0..4)
//   mem_data_o     packet-memory write data (always 0)
//   mem_data_i     read data, byte at mem_addr_o in [31:24]
//   tx_valid_o     output beat valid
//   tx_data_o      output beat data, unused trailing bytes zeroed
//   tx_keep_o      byte enables, bit 3 = byte [31:24]
//   tx_last_o      final beat of the packet
//   tx_ready_i     sink accepts the current beat
//   ready_o        packet fully emitted
// ---------------------------------------------------------------------------

`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 2
`endif
`ifndef NO_HEADER
`define NO_HEADER 16'hFFFF
`endif

module deparser (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [`ADDR_BUS-1:0]                  pkt_len_i,
    input  logic [`WORD_WIDTH*`NUM_HEADERS-1:0]   parsed_hdrs_i,
    output logic                                  mem_ce_o,
    output logic                                  mem_we_o,
    output logic [`ADDR_BUS-1:0]                  mem_addr_o,
    output logic [3:0]                            mem_width_o,
    output logic [`DATA_BUS-1:0]                  mem_data_o,
    input  logic [`DATA_BUS-1:0]                  mem_data_i,
    output logic                                  tx_valid_o,
    output logic [`DATA_BUS-1:0]                  tx_data_o,
    output logic [3:0]                            tx_keep_o,
    output logic                                  tx_last_o,
    input  logic                                  tx_ready_i,
    output logic                                  ready_o
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Bytes of the packet still to be emitted, counted from the current word.
    logic [`ADDR_BUS-1:0] rem_q;

    // Start offset S. The packet's first read address is S, so mem_addr_o
    // is the register that carries S forward once a packet is accepted.
    logic [`ADDR_BUS-1:0] start_off;

`ifdef DP_STRIP_L2_EN
    logic [`WORD_WIDTH-1:0] hdr1;
    logic                   unused_hdr0;

    assign hdr1        = parsed_hdrs_i[`WORD_WIDTH-1:0];
    assign start_off   = (hdr1 != `NO_HEADER) ? `ADDR_BUS'(hdr1) : '0;
    assign unused_hdr0 = &{1'b0, parsed_hdrs_i[`WORD_WIDTH*`NUM_HEADERS-1:`WORD_WIDTH]};
`else
    logic unused_hdrs;

    assign start_off   = '0;
    assign unused_hdrs = &{1'b0, parsed_hdrs_i};
`endif

    // The read port is never used to write.
    assign mem_we_o   = 1'b0;
    assign mem_data_o = '0;

    // Width of a word read: four bytes, or whatever is left at the tail.
    function automatic logic [3:0] clamp4(input logic [`ADDR_BUS-1:0] n);
        return (n >= `ADDR_BUS'(4)) ? 4'd4 : n[3:0];
    endfunction

    // Byte-enable pattern for a given width, filled from the top byte down.
    function automatic logic [3:0] keep_of(input logic [3:0] w);
        case (w)
            4'd0:    return 4'b0000;
            4'd1:    return 4'b1000;
            4'd2:    return 4'b1100;
            4'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    // A start with nothing to send (length 0 or offset past the end)
    // bypasses memory entirely. S >= pkt_len also covers pkt_len == 0.
    logic start_skip;
    logic accept;
    logic [`ADDR_BUS-1:0] rem_after;
    logic [3:0]           load_keep;
    logic [`DATA_BUS-1:0] load_data;

    assign start_skip = (start_off >= pkt_len_i);
    assign accept     = tx_valid_o && tx_ready_i;
    assign rem_after  = rem_q - `ADDR_BUS'(mem_width_o);
    assign load_keep  = keep_of(mem_width_o);
    assign load_data  = mem_data_i & {{8{load_keep[3]}}, {8{load_keep[2]}},
                                      {8{load_keep[1]}}, {8{load_keep[0]}}};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE waits for start_i to drop so a held request
    // cannot retrigger the same packet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: if (start_i) state_d = start_skip ? DONE : LOAD;
            LOAD: state_d = SEND;
            SEND: if (accept) state_d = (rem_after == '0) ? DONE : LOAD;
            DONE: if (!start_i) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    // Datapath. All outputs are registered; the memory read issued in
    // LOAD returns in the same cycle and is captured into the beat, which
    // then sits in SEND until the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            mem_ce_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= 4'd0;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
            tx_keep_o   <= 4'd0;
            tx_last_o   <= 1'b0;
            ready_o     <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start_i) begin
                        if (start_skip) begin
                            rem_q    <= '0;
                            mem_ce_o <= 1'b0;
                            ready_o  <= 1'b1;
                        end else begin
                            rem_q       <= pkt_len_i - start_off;
                            mem_ce_o    <= 1'b1;
                            mem_addr_o  <= start_off;
                            mem_width_o <= clamp4(pkt_len_i - start_off);
                            ready_o     <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    tx_data_o  <= load_data;
                    tx_keep_o  <= load_keep;
                    tx_last_o  <= (rem_q <= `ADDR_BUS'(4));
                    tx_valid_o <= 1'b1;
                end
                SEND: begin
                    if (accept) begin
                        tx_valid_o <= 1'b0;
                        tx_last_o  <= 1'b0;
                        rem_q      <= rem_after;
                        if (rem_after == '0) begin
                            mem_ce_o <= 1'b0;
                            ready_o  <= 1'b1;
                        end else begin
                            mem_addr_o  <= mem_addr_o + `ADDR_BUS'(4);
                            mem_width_o <= clamp4(rem_after);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
